// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared encodings for the pipelined immediate generator.
// Holds the imm_src select encodings, the RV opcodes used for automatic
// format decode, the internal format enum and the two format-decode helpers.
package imm_gen_pkg;

   // imm_src select encodings
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_Z = 3'b101;

   // major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // internal format; FMT_ZERO is R-type (immediate 0, no error)
   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_Z,
      FMT_ZERO,
      FMT_ILL
   } fmt_e;

   // format from the explicit select
   function automatic fmt_e fmt_from_src(input logic [2:0] src);
      fmt_e f;
      case (src)
         IMM_I:   f = FMT_I;
         IMM_S:   f = FMT_S;
         IMM_B:   f = FMT_B;
         IMM_U:   f = FMT_U;
         IMM_J:   f = FMT_J;
         IMM_Z:   f = FMT_Z;
         default: f = FMT_ILL;
      endcase
      return f;
   endfunction

   // format from the opcode field
   function automatic fmt_e fmt_from_opcode(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
         OPC_STORE:                      f = FMT_S;
         OPC_BRANCH:                     f = FMT_B;
         OPC_LUI, OPC_AUIPC:             f = FMT_U;
         OPC_JAL:                        f = FMT_J;
         OPC_SYSTEM:                     f = FMT_Z;
         OPC_OP:                         f = FMT_ZERO;
         default:                        f = FMT_ILL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extraction and extension.
// Builds a 32-bit sign-extended immediate per format, then sign-extends
// to XLEN. Optional macro IMM_GEN_ZICSR_EN makes the Z (CSR uimm) format legal;
// without it Z is reported as illegal.
module imm_ext_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  fmt_e            fmt,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   logic [31:0] raw;
   logic        unused_opc;

   // opcode bits carry no immediate data
   assign unused_opc = ^instr[6:0];

   // per-format field gather; Z keeps its upper bits zero so the final
   // sign extension still yields a zero extension
   always_comb begin
      raw = '0;
      err = 1'b0;
      case (fmt)
         FMT_I: raw = {{20{instr[31]}}, instr[31:20]};
         FMT_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
         FMT_U: raw = {instr[31:12], 12'b0};
         FMT_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
         FMT_Z: begin
`ifdef IMM_GEN_ZICSR_EN
            raw = {27'b0, instr[19:15]};
`else
            err = 1'b1;
`endif
         end
         FMT_ZERO: raw = '0;
         default:  err = 1'b1;
      endcase
      imm = err ? '0 : XLEN'($signed(raw));
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: 1- or 2-stage valid/ready pipelined immediate generator.
// Stage 1 registers the instruction and its decoded format; the extension is
// computed combinationally from stage 1, and stage 2 (PIPE_DEPTH=2) registers
// the result. Optional macro IMM_GEN_ZICSR_EN enables the Z (CSR) format.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PIPE_DEPTH  = 1,
   parameter int AUTO_DECODE = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_err
);

   fmt_e            in_fmt;
   logic            s1_valid;
   logic [31:0]     s1_instr;
   fmt_e            s1_fmt;
   logic            ready2;
   logic [XLEN-1:0] core_imm;
   logic            core_err;

   assign in_fmt   = (AUTO_DECODE != 0) ? fmt_from_opcode(instr[6:0])
                                        : fmt_from_src(imm_src);
   assign in_ready = !s1_valid || ready2;

   // stage 1: capture instruction and format on an accepting edge
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_instr <= '0;
         s1_fmt   <= FMT_I;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_instr <= instr;
            s1_fmt   <= in_fmt;
         end
      end
   end

   imm_ext_core #(.XLEN(XLEN)) u_core (
      .instr (s1_instr),
      .fmt   (s1_fmt),
      .imm   (core_imm),
      .err   (core_err)
   );

   if (PIPE_DEPTH >= 2) begin : g_s2
      logic            s2_valid;
      logic [XLEN-1:0] s2_imm;
      logic            s2_err;

      assign ready2 = !s2_valid || out_ready;

      // stage 2: register the extended immediate; loading from an empty
      // stage 1 clears valid so no bubble is ever presented as data
      always_ff @(posedge clk) begin
         if (reset) begin
            s2_valid <= 1'b0;
            s2_imm   <= '0;
            s2_err   <= 1'b0;
         end else if (ready2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_imm <= core_imm;
               s2_err <= core_err;
            end
         end
      end

      assign out_valid = s2_valid;
      assign imm_ext   = s2_imm;
      assign imm_err   = s2_err;
   end else begin : g_s1
      assign ready2    = out_ready;
      assign out_valid = s1_valid;
      assign imm_ext   = core_imm;
      assign imm_err   = core_err;
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: two instances share stimulus:
//   dut_a: XLEN=32, PIPE_DEPTH=2, imm_src select
//   dut_b: XLEN=64, PIPE_DEPTH=1, opcode decode
// A queue-based model per instance predicts in_ready, out_valid and data.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [2:0]  imm_src;

   logic        a_in_ready, a_out_valid, a_err;
   logic [31:0] a_imm;
   logic        b_in_ready, b_out_valid, b_err;
   logic [63:0] b_imm;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(2), .AUTO_DECODE(0)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid),
      .out_ready(out_ready), .imm_ext(a_imm), .imm_err(a_err)
   );

   imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(1), .AUTO_DECODE(1)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .instr(instr), .imm_src(imm_src), .out_valid(b_out_valid),
      .out_ready(out_ready), .imm_ext(b_imm), .imm_err(b_err)
   );

   typedef struct {
      logic [63:0] imm;
      logic        err;
      int          acc;
   } item_t;

   item_t       q [2][$];
   int          cyc = 0;
   bit          cmp_en = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int depth_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int xlen_of(input int d);
      return (d == 0) ? 32 : 64;
   endfunction

   // 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z, 6 R (zero), 7 illegal
   function automatic int fmt_of(input int d, input logic [31:0] w, input logic [2:0] s);
      if (d == 0) return (s <= 3'd5) ? int'(s) : 7;
      case (w[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return 0;
         7'b0100011:                         return 1;
         7'b1100011:                         return 2;
         7'b0110111, 7'b0010111:             return 3;
         7'b1101111:                         return 4;
         7'b1110011:                         return 5;
         7'b0110011:                         return 6;
         default:                            return 7;
      endcase
   endfunction

   // {err, imm} computed arithmetically from the field weights
   function automatic logic [64:0] ref_imm(input int f, input logic [31:0] w, input int xl);
      longint      v = 0;
      logic        e = 1'b0;
      logic [63:0] r;
      case (f)
         0: begin
            v = longint'(w[31:20]);
            if (v >= 2048) v -= 4096;
         end
         1: begin
            v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
            if (v >= 2048) v -= 4096;
         end
         2: begin
            v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            if (v >= 4096) v -= 8192;
         end
         3: begin
            v = longint'(w[31:12]) * 4096;
            if (v >= 64'sd2147483648) v -= 64'sd4294967296;
         end
         4: begin
            v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
              + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            if (v >= 1048576) v -= 2097152;
         end
         5: begin
`ifdef IMM_GEN_ZICSR_EN
            v = longint'(w[19:15]);
`else
            e = 1'b1;
`endif
         end
         6: v = 0;
         default: e = 1'b1;
      endcase
      r = e ? 64'd0 : 64'(v);
      if (xl == 32) r[63:32] = '0;
      return {e, r};
   endfunction

   function automatic bit model_ir(input int d);
      return !(q[d].size() == depth_of(d) && !out_ready);
   endfunction

   function automatic bit model_ov(input int d);
      if (q[d].size() == 0) return 1'b0;
      return cyc >= q[d][0].acc + depth_of(d);
   endfunction

   // model update on each clock edge
   always @(posedge clk) begin
      bit          ov, ir;
      item_t       it;
      logic [64:0] r;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            q[d].delete();
         end else begin
            ov = model_ov(d);
            ir = model_ir(d);
            if (ov && out_ready) void'(q[d].pop_front());
            if (in_valid && ir) begin
               r = ref_imm(fmt_of(d, instr, imm_src), instr, xlen_of(d));
               it.imm = r[63:0];
               it.err = r[64];
               it.acc = cyc;
               q[d].push_back(it);
            end
         end
      end
      cyc++;
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      string       nm;
      logic        act_ir, act_ov, act_err;
      logic [63:0] act_imm;
      bit          eov;
      if (cmp_en) begin
         for (int d = 0; d < 2; d++) begin
            nm      = (d == 0) ? "a" : "b";
            act_ir  = (d == 0) ? a_in_ready : b_in_ready;
            act_ov  = (d == 0) ? a_out_valid : b_out_valid;
            act_err = (d == 0) ? a_err : b_err;
            act_imm = (d == 0) ? {32'd0, a_imm} : b_imm;
            eov     = model_ov(d);
            chk({nm, "_in_ready"}, 65'(act_ir), 65'(model_ir(d)));
            chk({nm, "_out_valid"}, 65'(act_ov), 65'(eov));
            if (eov && act_ov === 1'b1) begin
               chk({nm, "_imm_ext"}, 65'(act_imm), 65'(q[d][0].imm));
               chk({nm, "_imm_err"}, 65'(act_err), 65'(q[d][0].err));
            end
         end
      end
   end

   task automatic step(input logic v, input logic [31:0] w, input logic [2:0] s, input logic ordy);
      in_valid  = v;
      instr     = w;
      imm_src   = s;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_a_out_valid"}, 65'(a_out_valid), 65'd0);
      chk({tag, "_a_imm"}, 65'(a_imm), 65'd0);
      chk({tag, "_a_err"}, 65'(a_err), 65'd0);
      chk({tag, "_b_out_valid"}, 65'(b_out_valid), 65'd0);
      chk({tag, "_b_imm"}, 65'(b_imm), 65'd0);
      chk({tag, "_b_err"}, 65'(b_err), 65'd0);
   endtask

   logic [31:0] dir_w [10];
   logic [2:0]  dir_s [10];
   logic [6:0]  opcs  [11];

   initial begin
      logic [31:0] w;
      int          k;
      dir_w = '{32'hFFF00093, 32'h00112423, 32'hFE000EE3, 32'h001000EF,
                32'h123452B7, 32'h800002B7, 32'h00000013, 32'h000FD073,
                32'h002081B3, 32'hABCDE0AB};
      dir_s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd6, 3'd5, 3'd7, 3'd0};
      opcs  = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011,
                7'b0101011};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0; imm_src = '0;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_zero_outputs("post_reset");
      chk("post_reset_a_in_ready", 65'(a_in_ready), 65'd1);
      chk("post_reset_b_in_ready", 65'(b_in_ready), 65'd1);

      // pin the reference model with hand-computed values
      chk("pin_I", ref_imm(0, dir_w[0], 32), {1'b0, 64'h00000000FFFFFFFF});
      chk("pin_S", ref_imm(1, dir_w[1], 32), {1'b0, 64'h0000000000000008});
      chk("pin_B", ref_imm(2, dir_w[2], 32), {1'b0, 64'h00000000FFFFFFFC});
      chk("pin_J", ref_imm(4, dir_w[3], 32), {1'b0, 64'h0000000000000800});
      chk("pin_U64", ref_imm(fmt_of(1, dir_w[4], 3'd0), dir_w[4], 64),
          {1'b0, 64'h0000000012345000});
      chk("pin_U64_neg", ref_imm(fmt_of(1, dir_w[5], 3'd0), dir_w[5], 64),
          {1'b0, 64'hFFFFFFFF80000000});
      chk("pin_illegal", ref_imm(fmt_of(0, dir_w[6], 3'd6), dir_w[6], 32),
          {1'b1, 64'h0});
`ifdef IMM_GEN_ZICSR_EN
      chk("pin_Z", ref_imm(fmt_of(0, dir_w[7], 3'd5), dir_w[7], 32),
          {1'b0, 64'h000000000000001F});
`else
      chk("pin_Z", ref_imm(fmt_of(0, dir_w[7], 3'd5), dir_w[7], 32),
          {1'b1, 64'h0});
`endif

      // directed vectors back to back
      for (int i = 0; i < 10; i++) step(1'b1, dir_w[i], dir_s[i], 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);

      // backpressure: 4 I-type words, out_ready low for relative cycles 3..6
      k = 0;
      for (int c = 0; c < 14; c++) begin
         w = 32'h00100093 + (32'(k) << 20);
         in_valid  = (k < 4);
         instr     = w;
         imm_src   = 3'd0;
         out_ready = !(c >= 3 && c <= 6);
         @(negedge clk);
         if (c == 5) begin
            chk("bp_a_in_ready_full", 65'(a_in_ready), 65'd0);
            chk("bp_a_out_valid_held", 65'(a_out_valid), 65'd1);
            chk("bp_a_imm_held", 65'(a_imm), 65'd2);
         end
         if (in_valid && a_in_ready) k++;
         @(posedge clk); #1;
      end

      // reset with two entries in flight
      step(1'b1, 32'h00500093, 3'd0, 1'b0);
      step(1'b1, 32'h00600093, 3'd0, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_zero_outputs("mid_reset");
      step(1'b1, 32'h00700093, 3'd0, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_a_not_yet", 65'(a_out_valid), 65'd0);
      chk("lat_b_valid", 65'(b_out_valid), 65'd1);
      chk("lat_b_imm", 65'(b_imm), 65'd7);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_a_valid", 65'(a_out_valid), 65'd1);
      chk("lat_a_imm", 65'(a_imm), 65'd7);
      @(posedge clk); #1;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         w = $urandom;
         if ($urandom_range(0, 9) < 8) w[6:0] = opcs[$urandom_range(0, 10)];
         in_valid  = ($urandom_range(0, 9) < 7);
         instr     = w;
         imm_src   = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 9) < 7);
         reset     = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
